// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over req/ack, presents decoded fields.
// Ack edge -> InstrValid next cycle; Stall holds the instruction, PC and state in VALID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] InstrAddr,
  output logic        InstrReq,
  input  logic        InstrAck,
  input  logic [31:0] InstrData,
  input  logic        Stall,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [3:0]  Cond,
  output logic [1:0]  Op,
  output logic [5:0]  Funct,
  output logic [3:0]  Rn,
  output logic [3:0]  Rd,
  output logic [3:0]  Rm,
  output logic [31:0] PCPlus8
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        req;
  logic        vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= 32'h0;
      req   <= 1'b0;
      vld   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req   <= 1'b1;
          vld   <= 1'b0;
        end
        FETCH: begin
          if (InstrAck) begin
            instr <= InstrData;
            state <= VALID;
            req   <= 1'b0;
            vld   <= 1'b1;
          end
        end
        VALID: begin
          // Consume edge: redirect or fall through, then refetch immediately
          if (!Stall) begin
            pc    <= PCSrc ? {Result[31:2], 2'b00} : pc + 32'd4;
            state <= FETCH;
            req   <= 1'b1;
            vld   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
          vld   <= 1'b0;
        end
      endcase
    end
  end

  assign InstrAddr  = pc;
  assign InstrReq   = req;
  assign InstrValid = vld;
  assign Instr      = instr;
  assign Cond       = instr[31:28];
  assign Op         = instr[27:26];
  assign Funct      = instr[25:20];
  assign Rn         = instr[19:16];
  assign Rd         = instr[15:12];
  assign Rm         = instr[3:0];
  assign PCPlus8    = pc + 32'd8;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the ARM-subset processor. It sits directly upstream of the instruction decoder. It holds the PC and issues word-aligned requests to instruction memory over a req/ack handshake, then captures the returned word in an instruction register. The Cond/Op/Funct/Rd/Rn/Rm fields presented to the decoder and register file are sliced from that register. When the held instruction is consumed, the PC advances to PC+4 or to the branch target selected by the conditional logic.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- InstrAddr  output  32  fetch address (= PC), stable while InstrReq=1
- InstrReq  output  1  fetch request, registered
- InstrAck  input  1  memory has InstrData valid this cycle; ignored when InstrReq=0
- InstrData  input  32  instruction word, sampled on edge where InstrReq=1 && InstrAck=1
- Stall  input  1  downstream cannot consume the held instruction this cycle
- PCSrc  input  1  from conditional logic: held instruction redirects the PC
- Result  input  32  branch/PC-write target; bits [1:0] ignored (forced 00)
- Instr  output  32  instruction register contents
- InstrValid  output  1  Instr holds an unconsumed instruction
- Cond  output  4  Instr[31:28]
- Op  output  2  Instr[27:26]
- Funct  output  6  Instr[25:20]
- Rn  output  4  Instr[19:16]
- Rd  output  4  Instr[15:12]
- Rm  output  4  Instr[3:0]
- PCPlus8  output  32  PC+8 of the held instruction, mod 2^32

## Operation
- The PC register equals InstrAddr. It changes only on a consume edge.
- FSM states: IDLE, FETCH, VALID.
  - IDLE: the reset state. Goes to FETCH unconditionally at the first edge after reset_n rises.
  - FETCH: InstrReq=1, InstrValid=0.
    - On an edge with InstrAck=1: Instr <= InstrData, go to VALID.
    - Otherwise stay in FETCH, with InstrAddr and InstrReq held stable.
  - VALID: InstrReq=0, InstrValid=1.
    - On an edge with Stall=0 (consume): PC <= PCSrc ? {Result[31:2],2'b00} : PC+4, then go to FETCH.
    - On an edge with Stall=1: hold Instr, PC and state.
- PCSrc and Result are sampled only on a consume edge; they are don't-care otherwise.
- Stall is ignored outside VALID.
- Field outputs are pure slices of Instr and are always driven. Consumers qualify them with InstrValid.
- Arithmetic rules: PC+4 and PC+8 are 32-bit and wrap modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000). No carry out.
- InstrAck may arrive in the same cycle InstrReq first rises (zero-wait memory).
- An InstrAck pulse while InstrReq=0 has no effect.

## Timing
- Reset values (asynchronous, while reset_n=0): state=IDLE, PC=RESET_PC, InstrReq=0, InstrValid=0, Instr=0. Derived outputs follow: Cond/Op/Funct/Rn/Rd/Rm=0, PCPlus8=RESET_PC+8.
- Reset asserted mid-fetch or mid-hold: all of the above take effect immediately, without waiting for a clock edge. Any in-flight request is abandoned; a late InstrAck is ignored because the FSM is in IDLE.
- First InstrReq=1 appears one edge after reset release.
- Latency: the edge with InstrAck=1 makes InstrValid=1 in the following cycle.
- Throughput: with zero-wait memory and Stall=0, one instruction every 2 cycles (FETCH, VALID alternating).
- The new InstrAddr is visible in the cycle after the consume edge, with InstrReq=1 in that same cycle.
- N wait cycles of memory add exactly N cycles to the FETCH state.

## Test plan
- Reset with RESET_PC=0x100, release reset_n, zero-wait ack, Stall=0, PCSrc=0 -> InstrAddr sequence 0x100, 0x104, 0x108. InstrReq and InstrValid alternate. PCPlus8=0x108 while the first instruction is held.
- Fetch word 0xE3A0_1005 -> Cond=0xE, Op=00, Funct=0x3A, Rn=0, Rd=1, Rm=5, InstrValid=1.
- Memory with 3 wait cycles -> InstrReq held high 4 cycles with InstrAddr constant. Ack pulses injected while InstrReq=0 do not change Instr.
- Stall=1 held 5 cycles in VALID -> Instr, PC and InstrValid stay constant. Releasing Stall with PCSrc=1 and Result=0x0000_2003 -> next InstrAddr=0x0000_2000.
- PC=0xFFFF_FFFC, consume with PCSrc=0 -> next InstrAddr=0x0000_0000, and PCPlus8 was 0x0000_0004.
- Assert reset_n=0 mid-FETCH between clock edges -> InstrReq=0, InstrValid=0 and PC=RESET_PC immediately. After release, fetch restarts at RESET_PC.
